swc_rtu_rsp_arbiter: RTL and testbench
======================================

Name: swc_rtu_rsp_arbiter

Overview:
- Round-robin scheduler that shares the swcore's single page-transfer issue slot among the per-port RTU response handshakes.
- Sits between the RTU response bus (per-port valid/ack, dst mask, drop, prio) and the core's transfer-issue logic.
- Grants one port at a time, forwards its decision, and returns the per-port ack.
- Filters drops and self-forwarding, and keeps a saturating discard counter.

Parameters:
- g_num_ports, 7, number of switch ports N (2..16).
- g_prio_width, 3, width W of the per-port priority field.
- g_cnt_width, 16, width of the discard counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- rtu_rsp_valid_i  in  N  per-port RTU response valid; held until acked.
- rtu_rsp_ack_o  out  N  per-port one-cycle ack pulse.
- rtu_dst_port_mask_i  in  N*N  dst mask; port p occupies bits [p*N+N-1 : p*N].
- rtu_drop_i  in  N  per-port drop flag.
- rtu_prio_i  in  N*W  per-port priority; port p occupies bits [p*W+W-1 : p*W].
- xfer_valid_o  out  1  transfer request to the core.
- xfer_ready_i  in  1  core accepts the request when xfer_valid_o=1 and xfer_ready_i=1.
- xfer_src_o  out  ceil(log2 N)  granted source port.
- xfer_dst_mask_o  out  N  filtered destination mask.
- xfer_prio_o  out  W  granted priority.
- discard_cnt_o  out  g_cnt_width  count of responses discarded.

Behaviour:
- Reset (rst_i=1 sampled at a clk_i edge):
  - state=IDLE, rr pointer=0; all outputs 0.
  - Any in-progress grant is abandoned with no ack.
- FSM states: IDLE, ISSUE, ACK.
- IDLE arbitration:
  - If any rtu_rsp_valid_i is set, pick the first set bit searching from ptr upward, wrapping at N-1 to 0. Call it g.
  - Register src=g, prio=prio[g], mask=dst_mask[g] with bit g cleared (no self-forward).
  - Set ptr=(g+1) mod N.
- IDLE next state:
  - Go to ACK (discard) if drop[g]=1 or the filtered mask is 0. discard_cnt_o increments, saturating at all-ones.
  - Otherwise go to ISSUE.
- ISSUE:
  - xfer_valid_o=1 with registered src/mask/prio held stable.
  - Stays in ISSUE while xfer_ready_i=0; on handshake go to ACK.
  - Input changes on port g during ISSUE are ignored; the registered values are used.
- ACK:
  - rtu_rsp_ack_o[g]=1 for exactly one cycle; xfer_valid_o=0; no arbitration.
  - Next state is IDLE. This gives the requester one cycle to drop valid.
- Latency:
  - Forwarded response: valid seen in IDLE at cycle t → xfer_valid_o at t+1 → ack at (handshake cycle)+1.
  - Minimum is 3 cycles per response.
  - Discarded response: ack at t+1, 2 cycles per response.
- Fairness: with all N ports continuously requesting, each port is served once per N grants; no starvation.
- Invariants:
  - At most one rtu_rsp_ack_o bit is set at any time.
  - rtu_rsp_ack_o is never asserted for a port whose valid was 0 in the granting IDLE cycle.
- xfer_ready_i asserted outside ISSUE is ignored.
- Reset while in ISSUE: the next cycle shows xfer_valid_o=0 and no ack; the port re-arbitrates from ptr=0.

Decomposition:
- Package swc_rtu_arb_pkg:
  - state enum t_arb_state {IDLE, ISSUE, ACK}.
  - Function f_log2_ceil.
  - Constant c_src_width.
- Sub-module swc_rr_pick (combinational):
  - Inputs: req[N], ptr.
  - Outputs: grant index and any_req.
  - Implemented as a doubled-vector priority search; reused by other swcore arbiters.

Test Plan:
- Single request: port 3 valid, mask 0x7F, drop=0, prio=5, xfer_ready_i=1 → xfer_src_o=3, xfer_dst_mask_o=0x77, xfer_prio_o=5 one cycle after valid; ack[3] two cycles later, pulse width 1.
- Round-robin: ports 0, 2, 6 held valid with ready=1 (each drops valid after its ack, then reasserts) → grant order 0,2,6,0,2,6; every ack a single pulse.
- Backpressure: port 1 forwarded, xfer_ready_i=0 for 5 cycles → xfer_valid_o and outputs stable for 6 cycles; a change on port 1's input mask meanwhile is not reflected; ack[1] the cycle after ready=1.
- Discard paths:
  - Port 4 with drop=1 → no xfer_valid_o, ack[4] at t+1, discard_cnt_o=1.
  - Port 5 with mask 0x20 (self only) → discard, discard_cnt_o=2.
- Saturation: g_cnt_width=2, 5 drops → discard_cnt_o=3, then held.
- Reset mid-ISSUE: assert rst_i for 1 cycle during ISSUE → outputs 0, no ack; port still valid → re-granted; the pointer restart from 0 is visible when ports 0 and 6 request together.

Source files
------------

// File: rtl/swc_rtu_arb_pkg.sv
// Shared types and helpers for the swcore RTU response arbiters.
package swc_rtu_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} t_arb_state;

    function automatic int f_log2_ceil(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    localparam int c_max_ports = 16;
    // Index width wide enough for the largest supported switch.
    localparam int c_src_width = f_log2_ceil(c_max_ports);

endpackage

// File: rtl/swc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module swc_rr_pick
    import swc_rtu_arb_pkg::*;
#(
    parameter int g_num_ports = 7,
    parameter int g_idx_width = f_log2_ceil(g_num_ports)
) (
    input  logic [g_num_ports-1:0] req,
    input  logic [g_idx_width-1:0] ptr,
    output logic [g_idx_width-1:0] grant,
    output logic                   any_req
);

    // Rotating the doubled vector puts the ptr position at bit 0.
    logic [g_num_ports-1:0] win;
    assign win = g_num_ports'({req, req} >> ptr);

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = 0; i < g_num_ports; i++) begin
            if (!any_req && win[i]) begin
                any_req = 1'b1;
                grant   = g_idx_width'((int'(ptr) + i) % g_num_ports);
            end
        end
    end

endmodule

// File: rtl/swc_rtu_rsp_arbiter.sv
// Shares the single page-transfer issue slot among per-port RTU responses,
// dropping discards and self-forwards and counting them.
module swc_rtu_rsp_arbiter
    import swc_rtu_arb_pkg::*;
#(
    parameter int g_num_ports  = 7,
    parameter int g_prio_width = 3,
    parameter int g_cnt_width  = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [g_num_ports-1:0]                    rtu_rsp_valid_i,
    output logic [g_num_ports-1:0]                    rtu_rsp_ack_o,
    input  logic [g_num_ports*g_num_ports-1:0]        rtu_dst_port_mask_i,
    input  logic [g_num_ports-1:0]                    rtu_drop_i,
    input  logic [g_num_ports*g_prio_width-1:0]       rtu_prio_i,
    output logic                                      xfer_valid_o,
    input  logic                                      xfer_ready_i,
    output logic [f_log2_ceil(g_num_ports)-1:0]       xfer_src_o,
    output logic [g_num_ports-1:0]                    xfer_dst_mask_o,
    output logic [g_prio_width-1:0]                   xfer_prio_o,
    output logic [g_cnt_width-1:0]                    discard_cnt_o
);

    localparam int SW = f_log2_ceil(g_num_ports);

    typedef logic [g_num_ports-1:0] t_mask;

    typedef struct packed {
        logic [SW-1:0]           src;
        t_mask                   mask;
        logic [g_prio_width-1:0] prio;
    } t_grant;

    logic [g_num_ports-1:0][g_num_ports-1:0]  dst_arr;
    logic [g_num_ports-1:0][g_prio_width-1:0] prio_arr;

    assign dst_arr  = rtu_dst_port_mask_i;
    assign prio_arr = rtu_prio_i;

    t_arb_state    state;
    t_grant        grant_q;
    logic [SW-1:0] ptr;
    logic [SW-1:0] pick;
    logic          any_req;
    t_mask         self_bit;
    t_mask         filt_mask;

    swc_rr_pick #(
        .g_num_ports (g_num_ports),
        .g_idx_width (SW)
    ) u_pick (
        .req     (rtu_rsp_valid_i),
        .ptr     (ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    assign self_bit  = t_mask'(1) << pick;
    assign filt_mask = dst_arr[pick] & ~self_bit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_q       <= '0;
            xfer_valid_o  <= 1'b0;
            rtu_rsp_ack_o <= '0;
            discard_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rtu_rsp_ack_o <= '0;
                    if (any_req) begin
                        grant_q.src  <= pick;
                        grant_q.mask <= filt_mask;
                        grant_q.prio <= prio_arr[pick];
                        ptr          <= (pick == SW'(g_num_ports - 1)) ? '0 : pick + 1'b1;
                        if (rtu_drop_i[pick] || filt_mask == '0) begin
                            // Discards skip the core and are acked straight away.
                            state         <= ACK;
                            rtu_rsp_ack_o <= self_bit;
                            if (discard_cnt_o != '1)
                                discard_cnt_o <= discard_cnt_o + 1'b1;
                        end else begin
                            state        <= ISSUE;
                            xfer_valid_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (xfer_ready_i) begin
                        state         <= ACK;
                        xfer_valid_o  <= 1'b0;
                        rtu_rsp_ack_o <= t_mask'(1) << grant_q.src;
                    end
                end
                ACK: begin
                    // One idle cycle lets the requester drop valid before re-arbitration.
                    state         <= IDLE;
                    rtu_rsp_ack_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign xfer_src_o      = grant_q.src;
    assign xfer_dst_mask_o = grant_q.mask;
    assign xfer_prio_o     = grant_q.prio;

endmodule

// File: tb/tb_swc_rtu_rsp_arbiter.sv
// Self-checking bench for swc_rtu_rsp_arbiter: directed scenarios plus randomized traffic.
module tb_swc_rtu_rsp_arbiter;

    localparam int N  = 7;
    localparam int W  = 3;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   valid, drop, ack, xmask, s_ack, s_xmask;
    logic [N*N-1:0] dst;
    logic [N*W-1:0] prio;
    logic           ready, xv, s_xv;
    logic [SW-1:0]  src, s_src;
    logic [W-1:0]   xprio, s_xprio;
    logic [15:0]    cnt;
    logic [1:0]     s_cnt;

    int vec = 0;
    int err = 0;
    int mptr = 0;
    int exp_cnt = 0;

    swc_rtu_rsp_arbiter #(.g_num_ports(N), .g_prio_width(W), .g_cnt_width(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .rtu_rsp_valid_i(valid), .rtu_rsp_ack_o(ack),
        .rtu_dst_port_mask_i(dst), .rtu_drop_i(drop), .rtu_prio_i(prio),
        .xfer_valid_o(xv), .xfer_ready_i(ready), .xfer_src_o(src),
        .xfer_dst_mask_o(xmask), .xfer_prio_o(xprio), .discard_cnt_o(cnt)
    );

    swc_rtu_rsp_arbiter #(.g_num_ports(N), .g_prio_width(W), .g_cnt_width(2)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .rtu_rsp_valid_i(valid), .rtu_rsp_ack_o(s_ack),
        .rtu_dst_port_mask_i(dst), .rtu_drop_i(drop), .rtu_prio_i(prio),
        .xfer_valid_o(s_xv), .xfer_ready_i(ready), .xfer_src_o(s_src),
        .xfer_dst_mask_o(s_xmask), .xfer_prio_o(s_xprio), .discard_cnt_o(s_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [N-1:0] m,
                            input logic d, input logic [W-1:0] pr);
        valid[p]       = v;
        dst[p*N +: N]  = m;
        drop[p]        = d;
        prio[p*W +: W] = pr;
    endtask

    task automatic do_reset;
        valid = '0;
        drop  = '0;
        ready = 1'b0;
        rst   = 1'b1;
        step();
        rst     = 1'b0;
        mptr    = 0;
        exp_cnt = 0;
    endtask

    task automatic test_reset;
        dst  = '0;
        prio = '0;
        do_reset();
        step();
        vec++;
        if ({xv, ack, src, xmask, xprio, cnt} !== '0) begin
            err++;
            $display("FAIL reset_outputs: got xv=%0b ack=%h src=%0d mask=%h prio=%0d cnt=%0d, exp all 0",
                     xv, ack, src, xmask, xprio, cnt);
        end
        vec++;
        if (s_cnt !== 2'd0) begin
            err++;
            $display("FAIL reset_sat_cnt: got %0d exp 0", s_cnt);
        end
    endtask

    task automatic test_single;
        do_reset();
        ready = 1'b1;
        set_port(3, 1'b1, 7'h7F, 1'b0, 3'd5);
        step();
        vec++;
        if ({xv, src, xmask, xprio, ack} !== {1'b1, 3'd3, 7'h77, 3'd5, 7'h00}) begin
            err++;
            $display("FAIL single_issue: got xv=%0b src=%0d mask=%h prio=%0d ack=%h, exp 1/3/77/5/00",
                     xv, src, xmask, xprio, ack);
        end
        step();
        vec++;
        if ({xv, ack} !== {1'b0, 7'h08}) begin
            err++;
            $display("FAIL single_ack: got xv=%0b ack=%h, exp 0/08", xv, ack);
        end
        valid[3] = 1'b0;
        step();
        vec++;
        if (ack !== 7'h00) begin
            err++;
            $display("FAIL single_ack_width: got ack=%h exp 00", ack);
        end
    endtask

    task automatic test_round_robin;
        int order[6] = '{0, 2, 6, 0, 2, 6};
        logic [N-1:0] eack;
        do_reset();
        ready = 1'b1;
        set_port(0, 1'b1, 7'h7F, 1'b0, 3'd0);
        set_port(2, 1'b1, 7'h7F, 1'b0, 3'd2);
        set_port(6, 1'b1, 7'h7F, 1'b0, 3'd6);
        for (int i = 0; i < 6; i++) begin
            step();
            vec++;
            if ({xv, src} !== {1'b1, SW'(order[i])}) begin
                err++;
                $display("FAIL rr_grant%0d: got xv=%0b src=%0d exp 1/%0d", i, xv, src, order[i]);
            end
            step();
            eack = '0;
            eack[order[i]] = 1'b1;
            vec++;
            if (ack !== eack) begin
                err++;
                $display("FAIL rr_ack%0d: got ack=%h exp %h", i, ack, eack);
            end
            valid[order[i]] = 1'b0;
            step();
            vec++;
            if ({xv, ack} !== '0) begin
                err++;
                $display("FAIL rr_pulse%0d: got xv=%0b ack=%h exp 0/00", i, xv, ack);
            end
            valid[order[i]] = 1'b1;
        end
        valid = '0;
    endtask

    task automatic test_backpressure;
        do_reset();
        set_port(1, 1'b1, 7'h7F, 1'b0, 3'd2);
        step();
        vec++;
        if ({xv, src, xmask, xprio} !== {1'b1, 3'd1, 7'h7D, 3'd2}) begin
            err++;
            $display("FAIL bp_issue: got xv=%0b src=%0d mask=%h prio=%0d exp 1/1/7d/2",
                     xv, src, xmask, xprio);
        end
        set_port(1, 1'b1, 7'h0F, 1'b0, 3'd6);
        for (int i = 0; i < 5; i++) begin
            step();
            vec++;
            if ({xv, src, xmask, xprio, ack} !== {1'b1, 3'd1, 7'h7D, 3'd2, 7'h00}) begin
                err++;
                $display("FAIL bp_hold%0d: got xv=%0b src=%0d mask=%h prio=%0d ack=%h exp 1/1/7d/2/00",
                         i, xv, src, xmask, xprio, ack);
            end
        end
        ready = 1'b1;
        step();
        vec++;
        if ({xv, ack} !== {1'b0, 7'h02}) begin
            err++;
            $display("FAIL bp_ack: got xv=%0b ack=%h exp 0/02", xv, ack);
        end
        ready    = 1'b0;
        valid[1] = 1'b0;
        step();
    endtask

    task automatic test_discard;
        do_reset();
        ready = 1'b1;
        set_port(4, 1'b1, 7'h7F, 1'b1, 3'd0);
        step();
        vec++;
        if ({xv, ack, cnt} !== {1'b0, 7'h10, 16'd1}) begin
            err++;
            $display("FAIL discard_drop: got xv=%0b ack=%h cnt=%0d exp 0/10/1", xv, ack, cnt);
        end
        set_port(4, 1'b0, 7'h7F, 1'b0, 3'd0);
        step();
        set_port(5, 1'b1, 7'h20, 1'b0, 3'd0);
        step();
        vec++;
        if ({xv, ack, cnt} !== {1'b0, 7'h20, 16'd2}) begin
            err++;
            $display("FAIL discard_self: got xv=%0b ack=%h cnt=%0d exp 0/20/2", xv, ack, cnt);
        end
        valid[5] = 1'b0;
        ready    = 1'b0;
        step();
    endtask

    task automatic test_saturation;
        int sat;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            set_port(0, 1'b1, 7'h7F, 1'b1, 3'd0);
            step();
            sat = (k > 3) ? 3 : k;
            vec++;
            if ({cnt, s_cnt, ack} !== {16'(k), 2'(sat), 7'h01}) begin
                err++;
                $display("FAIL sat_%0d: got cnt=%0d sat_cnt=%0d ack=%h exp %0d/%0d/01",
                         k, cnt, s_cnt, ack, k, sat);
            end
            valid[0] = 1'b0;
            step();
        end
        drop = '0;
        step();
        vec++;
        if (s_cnt !== 2'd3) begin
            err++;
            $display("FAIL sat_hold: got %0d exp 3", s_cnt);
        end
    endtask

    task automatic test_reset_mid_issue;
        int order[3] = '{0, 5, 6};
        logic [N-1:0] eack;
        do_reset();
        set_port(5, 1'b1, 7'h7F, 1'b0, 3'd5);
        step();
        vec++;
        if ({xv, src} !== {1'b1, 3'd5}) begin
            err++;
            $display("FAIL rst_issue: got xv=%0b src=%0d exp 1/5", xv, src);
        end
        set_port(0, 1'b1, 7'h7F, 1'b0, 3'd0);
        set_port(6, 1'b1, 7'h7F, 1'b0, 3'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec++;
        if ({xv, ack, src, xmask, xprio} !== '0) begin
            err++;
            $display("FAIL rst_mid_issue: got xv=%0b ack=%h src=%0d mask=%h prio=%0d exp all 0",
                     xv, ack, src, xmask, xprio);
        end
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vec++;
            if ({xv, src} !== {1'b1, SW'(order[i])}) begin
                err++;
                $display("FAIL rst_regrant%0d: got xv=%0b src=%0d exp 1/%0d", i, xv, src, order[i]);
            end
            step();
            eack = '0;
            eack[order[i]] = 1'b1;
            vec++;
            if (ack !== eack) begin
                err++;
                $display("FAIL rst_ack%0d: got ack=%h exp %h", i, ack, eack);
            end
            valid[order[i]] = 1'b0;
            step();
        end
        ready = 1'b0;
    endtask

    // Reference: a grant goes to the first pending port from the model pointer;
    // its timing follows the documented latencies per transaction.
    task automatic test_random;
        int g, waits, sat;
        logic [N-1:0] em, eack;
        logic [W-1:0] ep;
        bit disc;
        do_reset();
        for (int t = 0; t < 120; t++) begin
            for (int p = 0; p < N; p++) begin
                if (!valid[p] && $urandom_range(2) == 0) begin
                    if ($urandom_range(3) == 0)
                        set_port(p, 1'b1, N'(1 << p), 1'b0, W'($urandom));
                    else
                        set_port(p, 1'b1, N'($urandom), ($urandom_range(4) == 0), W'($urandom));
                end
            end
            if (valid == '0)
                set_port(int'($urandom_range(N - 1)), 1'b1, 7'h7F, 1'b0, W'($urandom));
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && valid[(mptr + k) % N]) g = (mptr + k) % N;
            em    = dst[g*N +: N];
            em[g] = 1'b0;
            ep    = prio[g*W +: W];
            disc  = drop[g] || (em == '0);
            mptr  = (g + 1) % N;
            eack  = '0;
            eack[g] = 1'b1;
            ready = $urandom_range(1);
            step();
            if (disc) begin
                exp_cnt++;
                vec++;
                if ({xv, ack, cnt} !== {1'b0, eack, 16'(exp_cnt)}) begin
                    err++;
                    $display("FAIL rnd_discard t=%0d: got xv=%0b ack=%h cnt=%0d exp 0/%h/%0d",
                             t, xv, ack, cnt, eack, exp_cnt);
                end
            end else begin
                vec++;
                if ({xv, src, xmask, xprio, ack} !== {1'b1, SW'(g), em, ep, 7'h00}) begin
                    err++;
                    $display("FAIL rnd_issue t=%0d: got xv=%0b src=%0d mask=%h prio=%0d ack=%h exp 1/%0d/%h/%0d/00",
                             t, xv, src, xmask, xprio, ack, g, em, ep);
                end
                set_port(g, 1'b1, N'($urandom), $urandom_range(1), W'($urandom));
                waits = $urandom_range(3);
                ready = 1'b0;
                for (int w = 0; w < waits; w++) begin
                    step();
                    vec++;
                    if ({xv, src, xmask, xprio, ack} !== {1'b1, SW'(g), em, ep, 7'h00}) begin
                        err++;
                        $display("FAIL rnd_hold t=%0d: got xv=%0b src=%0d mask=%h prio=%0d ack=%h exp 1/%0d/%h/%0d/00",
                                 t, xv, src, xmask, xprio, ack, g, em, ep);
                    end
                end
                ready = 1'b1;
                step();
                vec++;
                if ({xv, ack} !== {1'b0, eack}) begin
                    err++;
                    $display("FAIL rnd_ack t=%0d: got xv=%0b ack=%h exp 0/%h", t, xv, ack, eack);
                end
            end
            valid[g] = 1'b0;
            ready    = $urandom_range(1);
            step();
            sat = (exp_cnt > 3) ? 3 : exp_cnt;
            vec++;
            if ({xv, ack, s_cnt} !== {1'b0, 7'h00, 2'(sat)}) begin
                err++;
                $display("FAIL rnd_idle t=%0d: got xv=%0b ack=%h sat_cnt=%0d exp 0/00/%0d",
                         t, xv, ack, s_cnt, sat);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec);
        $fatal(1);
    end

    initial begin
        valid = '0;
        drop  = '0;
        dst   = '0;
        prio  = '0;
        ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_discard();
        test_saturation();
        test_reset_mid_issue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
